// File: rtl/ball_game_sequencer.sv
// Game-flow sequencer for a brick-breaker game: serve, play, pause, miss, game over and level clear.
// Every transition waits for the end-of-frame tick except the MISS exit and the soft reset.
module ball_game_sequencer #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int BRICK_TARGET = 140
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [9:0]   xpos,
  input  logic [9:0]   ypos,
  input  logic         start,
  input  logic         run,
  input  logic         game_rst,
  input  logic         Bottom_Hit,
  input  logic [139:0] flag_reg,
  output logic         ball_run,
  output logic         ball_rst,
  output logic         field_clr,
  output logic         GameOver,
  output logic         LevelClear,
  output logic [2:0]   lives,
  output logic [7:0]   bricks_cleared,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_MISS  = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  lives_r, lives_nxt_s;
  logic [7:0]  serve_cnt_r, serve_cnt_nxt_s;
  logic [7:0]  bricks_r;
  logic        miss_pend_r;
  logic        game_rst_d_r;
  logic        ball_run_r, ball_rst_r, field_clr_r, game_over_r, level_clear_r;
  logic        ball_rst_nxt_s, field_clr_nxt_s;
  logic        frame_tick_s;

  function automatic logic [7:0] popcount140(input logic [139:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < 140; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

  assign frame_tick_s   = (xpos == 10'd0) && (ypos == 10'd479);
  assign ball_run       = ball_run_r;
  assign ball_rst       = ball_rst_r;
  assign field_clr      = field_clr_r;
  assign GameOver       = game_over_r;
  assign LevelClear     = level_clear_r;
  assign lives          = lives_r;
  assign bricks_cleared = bricks_r;
  assign state          = state_r;

  // Next-state, lives, serve counter and pulse requests
  always_comb begin
    state_nxt_s     = state_r;
    lives_nxt_s     = lives_r;
    serve_cnt_nxt_s = serve_cnt_r;
    ball_rst_nxt_s  = 1'b0;
    field_clr_nxt_s = 1'b0;
    if (game_rst) begin
      // A held soft reset only pulses on its first cycle
      state_nxt_s     = ST_IDLE;
      serve_cnt_nxt_s = 8'd0;
      ball_rst_nxt_s  = ~game_rst_d_r;
      field_clr_nxt_s = ~game_rst_d_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_tick_s && start) begin
            state_nxt_s     = ST_SERVE;
            lives_nxt_s     = 3'(LIVES);
            serve_cnt_nxt_s = 8'd0;
            ball_rst_nxt_s  = 1'b1;
            field_clr_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (!frame_tick_s) begin
            state_nxt_s = ST_SERVE;
          end else if (!start) begin
            state_nxt_s = ST_IDLE;
          end else if (serve_cnt_r == 8'(SERVE_FRAMES - 1)) begin
            state_nxt_s = ST_PLAY;
          end else begin
            serve_cnt_nxt_s = serve_cnt_r + 8'd1;
          end
        end
        ST_PLAY: begin
          if (!frame_tick_s) begin
            state_nxt_s = ST_PLAY;
          end else if (!start) begin
            state_nxt_s = ST_IDLE;
          end else if (miss_pend_r) begin
            state_nxt_s = ST_MISS;
          end else if (bricks_r >= 8'(BRICK_TARGET)) begin
            state_nxt_s = ST_WIN;
          end else if (!run) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
        ST_PAUSE: begin
          if (!frame_tick_s) begin
            state_nxt_s = ST_PAUSE;
          end else if (!start) begin
            state_nxt_s = ST_IDLE;
          end else if (run) begin
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        ST_MISS: begin
          ball_rst_nxt_s = 1'b1;
          if (lives_r <= 3'd1) begin
            state_nxt_s = ST_OVER;
            lives_nxt_s = 3'd0;
          end else begin
            state_nxt_s     = ST_SERVE;
            lives_nxt_s     = lives_r - 3'd1;
            serve_cnt_nxt_s = 8'd0;
          end
        end
        ST_OVER, ST_WIN: begin
          if (frame_tick_s && !start) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r       <= ST_IDLE;
      lives_r       <= 3'd0;
      serve_cnt_r   <= 8'd0;
      miss_pend_r   <= 1'b0;
      game_rst_d_r  <= 1'b0;
      ball_run_r    <= 1'b0;
      ball_rst_r    <= 1'b0;
      field_clr_r   <= 1'b0;
      game_over_r   <= 1'b0;
      level_clear_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      lives_r       <= lives_nxt_s;
      serve_cnt_r   <= serve_cnt_nxt_s;
      game_rst_d_r  <= game_rst;
      ball_run_r    <= (state_nxt_s == ST_PLAY);
      ball_rst_r    <= ball_rst_nxt_s;
      field_clr_r   <= field_clr_nxt_s;
      game_over_r   <= (state_nxt_s == ST_OVER);
      level_clear_r <= (state_nxt_s == ST_WIN);
      if (state_nxt_s == ST_MISS || state_nxt_s == ST_IDLE || state_nxt_s == ST_SERVE) begin
        miss_pend_r <= 1'b0;
      end else if (state_r == ST_PLAY && Bottom_Hit) begin
        miss_pend_r <= 1'b1;
      end else begin
        miss_pend_r <= miss_pend_r;
      end
    end
  end

  // Registered popcount of the cleared-brick flags
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bricks_r <= 8'd0;
    end else begin
      bricks_r <= popcount140(flag_reg);
    end
  end

endmodule

// File: doc/ball_game_sequencer.md
BALL_GAME_SEQUENCER -- requirements
Module: ball_game_sequencer

Interface
REQ-001 Parameter LIVES, default 3: lives loaded at game start (1..7).
REQ-002 Parameter SERVE_FRAMES, default 60: frames the ball is held at serve position before play (1..255).
REQ-003 Parameter BRICK_TARGET, default 140: number of cleared bricks that ends a level (1..140).
REQ-004 Port iCLK, input, 1: system/pixel clock; the only clock in the block.
REQ-005 Port iRST_N, input, 1: reset, asynchronous, active-low.
REQ-006 Port xpos, input, 10: current scan column.
REQ-007 Port ypos, input, 10: current scan row.
REQ-008 Port start, input, 1: game enable level (player switch).
REQ-009 Port run, input, 1: 1 = play, 0 = pause request.
REQ-010 Port game_rst, input, 1: synchronous soft reset level.
REQ-011 Port Bottom_Hit, input, 1: single-cycle pulse, ball touched bottom border.
REQ-012 Port flag_reg, input, 140: per-brick cleared flags.
REQ-013 Port ball_run, output, 1: enables per-frame ball position update.
REQ-014 Port ball_rst, output, 1: one-cycle pulse that returns the ball to its serve position and direction.
REQ-015 Port field_clr, output, 1: one-cycle pulse that clears all brick flags.
REQ-016 Port GameOver, output, 1: level, no lives remain.
REQ-017 Port LevelClear, output, 1: level, brick target reached.
REQ-018 Port lives, output, 3: remaining lives.
REQ-019 Port bricks_cleared, output, 8: count of set bits in flag_reg.
REQ-020 Port state, output, 3: encoded FSM state.

Function
REQ-021 frame_tick SHALL equal (xpos==0 && ypos==479); all FSM transitions except MISS exit and soft reset SHALL occur only on cycles with frame_tick=1.
REQ-022 The FSM SHALL have states IDLE=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, OVER=5, WIN=6; code 7 is unreachable and SHALL go to IDLE on the next cycle.
REQ-023 IDLE: start=1 at frame_tick -> SERVE; same cycle: pulse ball_rst and field_clr, lives<=LIVES, serve counter<=0.
REQ-024 SERVE: serve counter SHALL increment on each frame_tick; when it reaches SERVE_FRAMES-1 at frame_tick -> PLAY.
REQ-025 PLAY: ball_run=1; other states: ball_run=0.
REQ-026 A Bottom_Hit pulse in PLAY SHALL set sticky miss_pend; miss_pend SHALL clear on entering MISS, IDLE or SERVE.
REQ-027 PLAY at frame_tick, priority order: miss_pend -> MISS; else bricks_cleared>=BRICK_TARGET -> WIN; else run=0 -> PAUSE; else stay.
REQ-028 PAUSE: run=1 at frame_tick -> PLAY; a Bottom_Hit in PAUSE SHALL be ignored.
REQ-029 MISS lasts exactly one cycle: pulse ball_rst; if lives==1 -> OVER with lives<=0, else lives<=lives-1 -> SERVE with serve counter<=0.
REQ-030 lives SHALL never wrap below 0.
REQ-031 OVER: GameOver=1; start=0 at frame_tick -> IDLE.
REQ-032 WIN: LevelClear=1; start=0 at frame_tick -> IDLE.
REQ-033 start=0 at frame_tick in SERVE, PLAY or PAUSE -> IDLE.
REQ-034 bricks_cleared SHALL be the registered popcount of flag_reg, updated every cycle, one cycle latency, range 0..140.
REQ-035 game_rst=1 SHALL force IDLE on the next clock edge, clear miss_pend and the serve counter, pulse ball_rst and field_clr once, and override all other transitions.
REQ-036 ball_rst and field_clr SHALL each be high for exactly one cycle per triggering event.

Reset
REQ-037 iRST_N=0 SHALL immediately set: state=IDLE, lives=0, bricks_cleared=0, serve counter=0, miss_pend=0, ball_run=0, ball_rst=0, field_clr=0, GameOver=0, LevelClear=0.
REQ-038 Reset asserted mid-game SHALL abandon the game with no pulses emitted; after release, play resumes only through IDLE.

Verification
REQ-039 Reset release; start=1, run=1 -> IDLE->SERVE at first frame_tick, ball_rst and field_clr pulse once, lives=3; PLAY after 60 frame_ticks, ball_run=1.
REQ-040 In PLAY, Bottom_Hit pulse mid-frame -> MISS at next frame_tick, then SERVE with lives=2; three misses total -> OVER, GameOver=1, lives=0.
REQ-041 In PLAY, drive 140 flag bits set -> bricks_cleared=140, WIN at next frame_tick, LevelClear=1; start=0 -> IDLE.
REQ-042 Same frame_tick with miss_pend=1, bricks_cleared=140 and run=0 -> MISS taken.
REQ-043 run=0 in PLAY -> PAUSE, ball_run=0, Bottom_Hit ignored; run=1 -> PLAY at next frame_tick with lives unchanged.
REQ-044 game_rst pulse during SERVE -> IDLE next edge with a single ball_rst/field_clr pulse; iRST_N low mid-PLAY -> all outputs at reset values immediately, without waiting for a clock edge.
